// File: rtl/led_array_driver_if.sv
// LED driver config/status bundle: load strobe, mode, data, duty in;
// pending flag and LED drive out. master = controller, slave = driver.
interface led_array_driver_if #(
    parameter int N_LEDS = 10,
    parameter int PWM_W  = 8
);
    logic              ld;
    logic [1:0]        ld_mode;
    logic [N_LEDS-1:0] ld_data;
    logic [PWM_W-1:0]  ld_duty;
    logic              pending;
    logic [N_LEDS-1:0] led;

    modport master (
        output ld, ld_mode, ld_data, ld_duty,
        input  pending, led
    );

    modport slave (
        input  ld, ld_mode, ld_data, ld_duty,
        output pending, led
    );
endinterface

// File: rtl/led_array_driver.sv
// Registered LED-array driver: direct/bar/blink/chase, PWM brightness, shadowed config.
// Ports: clk, reset_n (async low), bus (slave: ld/ld_mode/ld_data/ld_duty in, pending/led out).
module led_array_driver #(
    parameter int N_LEDS    = 10,
    parameter int VAL_W     = 4,
    parameter int PWM_W     = 8,
    parameter int BLINK_DIV = 25_000_000
) (
    input logic              clk,
    input logic              reset_n,
    led_array_driver_if.slave bus
);
    typedef enum logic [1:0] {
        M_DIRECT = 2'd0,
        M_BAR    = 2'd1,
        M_BLINK  = 2'd2,
        M_CHASE  = 2'd3
    } mode_t;

    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    mode_t             sh_mode;
    logic [N_LEDS-1:0] sh_data;
    logic [PWM_W-1:0]  sh_duty;
    logic              pending;

    mode_t             act_mode;
    logic [N_LEDS-1:0] act_data;
    logic [PWM_W-1:0]  act_duty;

    logic [PWM_W-1:0]  pwm_cnt;
    logic [BW-1:0]     blink_cnt;
    logic              phase;
    logic [N_LEDS-1:0] rot;
    logic [N_LEDS-1:0] led;

    logic              pwm_on;
    logic              apply;
    logic              tick;
    logic [VAL_W-1:0]  bar_v;
    logic [N_LEDS-1:0] bar_pat;
    logic [N_LEDS-1:0] pattern;

    assign pwm_on = (&act_duty) | (pwm_cnt < act_duty);
    assign apply  = (&pwm_cnt) & pending;
    assign tick   = (blink_cnt == BW'(BLINK_DIV - 1));
    assign bar_v  = act_data[VAL_W-1:0];

    // Lit count saturates naturally: indices stop at N_LEDS-1.
    always_comb begin
        bar_pat = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            bar_pat[i] = (i < int'(bar_v));
        end
    end

    always_comb begin
        pattern = '0;
        unique case (act_mode)
            M_DIRECT: pattern = act_data;
            M_BAR:    pattern = bar_pat;
            M_BLINK:  pattern = phase ? act_data : '0;
            M_CHASE:  pattern = rot;
            default:  pattern = '0;
        endcase
    end

    // Shadow and pending; a load on the apply edge keeps pending set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_mode <= M_DIRECT;
            sh_data <= '0;
            sh_duty <= '0;
            pending <= 1'b0;
        end else if (bus.ld) begin
            sh_mode <= mode_t'(bus.ld_mode);
            sh_data <= bus.ld_data;
            sh_duty <= bus.ld_duty;
            pending <= 1'b1;
        end else if (apply) begin
            pending <= 1'b0;
        end
    end

    // Active config only changes at the last count of a PWM period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_mode <= M_DIRECT;
            act_data <= '0;
            act_duty <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (apply) begin
                act_mode <= sh_mode;
                act_data <= sh_data;
                act_duty <= sh_duty;
            end
        end
    end

    // Blink/chase timebase; apply restarts it and wins over a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
            rot       <= '0;
        end else if (apply) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
            rot       <= sh_data;
        end else if (tick) begin
            blink_cnt <= '0;
            phase     <= ~phase;
            rot       <= {rot[N_LEDS-2:0], rot[N_LEDS-1]};
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= '0;
        end else begin
            led <= pattern & {N_LEDS{pwm_on}};
        end
    end

    assign bus.pending = pending;
    assign bus.led     = led;
endmodule

// File: tb/tb_led_array_driver.sv
// Randomized and directed bench for led_array_driver against a timeline model.
// Model derives LEDs from edge index, last apply edge and config arithmetic.
module tb_led_array_driver;
    localparam int N    = 10;
    localparam int VW   = 4;
    localparam int PW   = 4;
    localparam int BDIV = 8;
    localparam int PER  = 1 << PW;

    logic clk = 1'b0;
    logic reset_n;

    led_array_driver_if #(.N_LEDS(N), .PWM_W(PW)) bus ();

    led_array_driver #(
        .N_LEDS(N), .VAL_W(VW), .PWM_W(PW), .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int sh_m, sh_d, sh_u;
    int ac_m, ac_d, ac_u;
    int pend;
    int e;
    int a_edge;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int pat(input int m, input int d, input int n);
        int v, r;
        case (m)
            0: return d;
            1: begin
                v = d & ((1 << VW) - 1);
                if (v > N) v = N;
                return (1 << v) - 1;
            end
            2: return (n % 2 == 0) ? d : 0;
            default: begin
                r = n % N;
                return ((d << r) | (d >> (N - r))) & ((1 << N) - 1);
            end
        endcase
    endfunction

    task automatic model_reset();
        sh_m = 0; sh_d = 0; sh_u = 0;
        ac_m = 0; ac_d = 0; ac_u = 0;
        pend = 0;
        e = 0;
        a_edge = -1;
    endtask

    // Called near a negedge; drives inputs, clocks once, checks outputs.
    task automatic step(input logic l, input int m, input int d,
                        input int u);
        int n, exp_led, on;
        bit app;
        bus.ld      = l;
        bus.ld_mode = 2'(m);
        bus.ld_data = N'(d);
        bus.ld_duty = PW'(u);
        @(posedge clk);
        n = (e - 1 - a_edge) / BDIV;
        on = (ac_u == PER - 1) || ((e % PER) < ac_u);
        exp_led = on ? pat(ac_m, ac_d, n) : 0;
        app = (e % PER == PER - 1) && (pend != 0);
        if (app) begin
            ac_m = sh_m; ac_d = sh_d; ac_u = sh_u;
            a_edge = e;
        end
        if (l) begin
            sh_m = m; sh_d = d; sh_u = u;
            pend = 1;
        end else if (app) begin
            pend = 0;
        end
        e++;
        #1;
        check("led", 32'(bus.led), 32'(exp_led));
        check("pending", 32'(bus.pending), 32'(pend));
        @(negedge clk);
        bus.ld = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 0, 0);
    endtask

    // Load, then clock through the apply edge A (bounded wait).
    task automatic load(input int m, input int d, input int u);
        int k;
        step(1'b1, m, d, u);
        k = 0;
        while (pend != 0 && k < 2 * PER) begin
            step(1'b0, 0, 0, 0);
            k++;
        end
        if (pend != 0) check("apply_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bus.ld = 1'b0; bus.ld_mode = '0; bus.ld_data = '0; bus.ld_duty = '0;
        reset_n = 1'b0;
        #2;
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        repeat (3) @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        idle(100);

        load(0, 'h2A5, 15);
        step(1'b0, 0, 0, 0);
        check("direct_a1", 32'(bus.led), 32'h2A5);
        idle(20);

        // BAR saturation
        load(1, 3, 15);  step(1'b0, 0, 0, 0);
        check("bar3", 32'(bus.led), 32'h007);
        load(1, 0, 15);  step(1'b0, 0, 0, 0);
        check("bar0", 32'(bus.led), 32'h000);
        load(1, 10, 15); step(1'b0, 0, 0, 0);
        check("bar10", 32'(bus.led), 32'h3FF);
        load(1, 15, 15); step(1'b0, 0, 0, 0);
        check("bar15", 32'(bus.led), 32'h3FF);

        // PWM duty 5: lit while pwm_cnt 0..4
        load(0, 'h3FF, 5);
        step(1'b0, 0, 0, 0);
        check("pwm_c0", 32'(bus.led), 32'h3FF);
        idle(4);
        check("pwm_c4", 32'(bus.led), 32'h3FF);
        idle(1);
        check("pwm_c5", 32'(bus.led), 32'h000);
        idle(26);
        load(0, 'h3FF, 0);  idle(20);
        load(0, 'h3FF, 15); idle(20);

        // BLINK
        load(2, 'h0F0, 15);
        step(1'b0, 0, 0, 0);
        check("blink_on", 32'(bus.led), 32'h0F0);
        idle(8);
        check("blink_off", 32'(bus.led), 32'h000);
        idle(8);
        check("blink_on2", 32'(bus.led), 32'h0F0);

        // CHASE
        load(3, 'h201, 15);
        step(1'b0, 0, 0, 0);
        check("chase0", 32'(bus.led), 32'h201);
        idle(8);
        check("chase1", 32'(bus.led), 32'h003);
        idle(8);
        check("chase2", 32'(bus.led), 32'h006);
        idle(100);

        // last write wins before the boundary
        while (e % PER != 2) idle(1);
        step(1'b1, 0, 'h111, 15);
        step(1'b1, 0, 'h222, 15);
        idle(14);
        step(1'b0, 0, 0, 0);
        check("lastwin", 32'(bus.led), 32'h222);
        idle(20);

        // ld exactly on the apply edge
        while (e % PER != 3) idle(1);
        step(1'b1, 0, 'h155, 15);
        while (e % PER != PER - 1) idle(1);
        step(1'b1, 0, 'h0AA, 15);
        check("coll_pend", 32'(bus.pending), 32'd1);
        step(1'b0, 0, 0, 0);
        check("coll_old", 32'(bus.led), 32'h155);
        idle(15);
        step(1'b0, 0, 0, 0);
        check("coll_new", 32'(bus.led), 32'h0AA);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                step(1'b1, $urandom_range(0, 3), $urandom_range(0, 1023),
                     $urandom_range(0, PER - 1));
            else
                step(1'b0, 0, 0, 0);
        end

        // async reset mid-run with a pending shadow
        load(3, 'h0C3, 15);
        idle(5);
        step(1'b1, 0, 'h3FF, 15);
        check("pre_rst_pend", 32'(bus.pending), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_led", 32'(bus.led), 32'd0);
        check("async_pend", 32'(bus.pending), 32'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
